traffic_input_conditioner: RTL and testbench
============================================

# traffic_input_conditioner

Front-end stage feeding `traffic_light`: turns raw pedestrian button and side-road sensor into clean, synchronous requests and provides the one-second timing tick the controller sequences on. Synchronises both asynchronous inputs, debounces them, latches a pedestrian request until the controller acknowledges it, and qualifies side-road presence over a minimum hold time. All outputs are registered in the `fast_clock` domain.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronised input must differ from its stable value before the stable value flips; ≥2
- `TICK_DIV`, 50_000_000: `fast_clock` cycles per `sec_tick` period; ≥2
- `SENSOR_HOLD_TICKS`, 3: `sec_tick` pulses the side sensor must stay stable-high before `side_req` asserts; ≥1

Ports:
- `fast_clock`  in  1  system clock; one clock only
- `reset`  in  1  asynchronous, active-low reset
- `walk_button`  in  1  raw pedestrian button, asynchronous, active-high
- `side_sensor`  in  1  raw side-road vehicle sensor, asynchronous, active-high
- `walk_ack`  in  1  one-cycle pulse from `traffic_light`: walk phase entered; clears `walk_req`
- `sec_tick`  out  1  one-cycle pulse every `TICK_DIV` cycles
- `walk_req`  out  1  latched pedestrian request
- `side_req`  out  1  qualified side-road presence (level)
- `walk_level`  out  1  debounced button level
- `side_level`  out  1  debounced sensor level

## Operation

- Reset (`reset`=0, asynchronous): all sync flops, stable levels, counters and outputs clear to 0. Release takes effect on next `fast_clock` rising edge.
- Synchroniser: two flops per raw input.
- Debounce (per input): counter increments each cycle sync2 ≠ stable; clears whenever sync2 = stable. Stable value flips on the cycle the counter is `DEBOUNCE_CYCLES-1` and inputs still differ; counter clears. Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach the stable level. Both directions debounced identically.
- `walk_req`: set on rising edge of debounced button (stable ∧ ¬stable_d); cleared by `walk_ack`. Same-cycle set and ack: set wins, `walk_req` stays 1. Ack with no request: no effect. Holding the button does not re-set after ack; a new press (release then press) is required.
- Tick: counter 0..`TICK_DIV-1`, wraps to 0; `sec_tick`=1 the cycle counter equals `TICK_DIV-1`. Free-running from reset release.
- `side_req`: hold counter clears while `side_level`=0; increments on `sec_tick` while `side_level`=1, saturating at `SENSOR_HOLD_TICKS`. `side_req`=1 while counter = `SENSOR_HOLD_TICKS`. `side_level` falling clears counter and `side_req` on the next edge.
- Reset mid-operation: any pending request, partial debounce or hold count discarded.

## Timing

- Edge k first samples new raw level → sync2 at edge k+1 → `walk_level`/`side_level` at edge k+1+`DEBOUNCE_CYCLES` → `walk_req` at edge k+2+`DEBOUNCE_CYCLES`.
- `walk_ack` sampled at edge n → `walk_req`=0 after edge n.
- `sec_tick` first pulse after `TICK_DIV` cycles from reset release, then every `TICK_DIV` cycles exactly.
- `side_req` rises the cycle after the `SENSOR_HOLD_TICKS`-th `sec_tick` counted with `side_level`=1; the tick coincident with `side_level` rising is not counted.
- `side_req` falls one cycle after `side_level` falls.

## Structure

- Shared `traffic_pkg`: light-encoding constants (main/side RED/YELLOW/GREEN 3-bit codes) and default values of the three parameters, so `traffic_light` and this block agree.
- Sub-module `input_debouncer` (2-flop sync + debounce counter, parameter `DEBOUNCE_CYCLES`, outputs `level`), instantiated twice. Request latch, tick divider and hold counter live in the top.

## Test plan

Use `DEBOUNCE_CYCLES`=4, `TICK_DIV`=10, `SENSOR_HOLD_TICKS`=3.
- Reset: hold `reset`=0 with both raw inputs toggling → every output 0; after release, first `sec_tick` 10 cycles later, then every 10.
- Clean press: `walk_button` 0→1 sampled at edge k, held → `walk_level`=1 at k+5, `walk_req`=1 at k+6; pulse `walk_ack` → `walk_req`=0 next cycle, stays 0 while button held.
- Glitch: `walk_button` high 3 cycles then low → `walk_level`, `walk_req` never assert; bounce 1-0-1 inside 4 cycles → debounce counter restarts.
- Collision: new press edge and `walk_ack` in same cycle → `walk_req` remains 1.
- Side hold: `side_sensor` held high → `side_req`=1 the cycle after 3rd counted tick; drop sensor → `side_level` falls after debounce, `side_req`=0 one cycle later; sensor high for only 2 ticks → `side_req` stays 0.
- Reset mid-operation: assert `reset` with `walk_req`=1 and hold count 2 → all clear immediately; after release, request absent until a fresh press.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light controller and its input conditioner.
// Latency: n/a (constants only).
// Backpressure: n/a.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic [2:0] MAIN_RED    = LIGHT_RED;
    localparam logic [2:0] MAIN_YELLOW = LIGHT_YELLOW;
    localparam logic [2:0] MAIN_GREEN  = LIGHT_GREEN;
    localparam logic [2:0] SIDE_RED    = LIGHT_RED;
    localparam logic [2:0] SIDE_YELLOW = LIGHT_YELLOW;
    localparam logic [2:0] SIDE_GREEN  = LIGHT_GREEN;

    localparam int DEF_DEBOUNCE_CYCLES   = 16;
    localparam int DEF_TICK_DIV          = 50_000_000;
    localparam int DEF_SENSOR_HOLD_TICKS = 3;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a symmetric debounce counter.
// Latency: level follows a raw change DEBOUNCE_CYCLES+1 edges after first sample.
// Backpressure: none; free-running.
module input_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any cycle agreeing with the stable value restarts the qualification window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_input_conditioner.sv
// Cleans pedestrian/side-road inputs into requests and generates the 1 s tick.
// Latency: walk_req 2+DEBOUNCE_CYCLES edges after raw press; side_req 1 cycle after qualifying tick.
// Backpressure: none; walk_req holds until walk_ack.
module traffic_input_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV          = DEF_TICK_DIV,
    parameter int SENSOR_HOLD_TICKS = DEF_SENSOR_HOLD_TICKS
) (
    input  logic fast_clock,
    input  logic reset,
    input  logic walk_button,
    input  logic side_sensor,
    input  logic walk_ack,
    output logic sec_tick,
    output logic walk_req,
    output logic side_req,
    output logic walk_level,
    output logic side_level
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(SENSOR_HOLD_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(SENSOR_HOLD_TICKS);

    logic          walk_level_d;
    logic          side_level_d;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_walk_db (
        .clk  (fast_clock),
        .rst_n(reset),
        .raw  (walk_button),
        .level(walk_level)
    );

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_side_db (
        .clk  (fast_clock),
        .rst_n(reset),
        .raw  (side_sensor),
        .level(side_level)
    );

    always_comb begin
        tick_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
    end

    // A tick only counts once side_level was already high the cycle before,
    // so the tick coincident with the rising level is ignored.
    always_comb begin
        hold_nxt = hold_cnt;
        if (!side_level) begin
            hold_nxt = '0;
        end else if (sec_tick && side_level_d && (hold_cnt != HOLD_MAX)) begin
            hold_nxt = hold_cnt + HW'(1);
        end
    end

    always_ff @(posedge fast_clock or negedge reset) begin
        if (!reset) begin
            tick_cnt     <= '0;
            sec_tick     <= 1'b0;
            hold_cnt     <= '0;
            side_req     <= 1'b0;
            walk_req     <= 1'b0;
            walk_level_d <= 1'b0;
            side_level_d <= 1'b0;
        end else begin
            tick_cnt     <= tick_nxt;
            sec_tick     <= (tick_nxt == TICK_LAST);
            hold_cnt     <= hold_nxt;
            side_req     <= (hold_nxt == HOLD_MAX);
            walk_level_d <= walk_level;
            side_level_d <= side_level;
            // A fresh press beats a simultaneous acknowledge.
            if (walk_level && !walk_level_d) begin
                walk_req <= 1'b1;
            end else if (walk_ack) begin
                walk_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output edges, a monitor checks every change.
module tb_traffic_input_conditioner;

    localparam int DB = 4;
    localparam int TD = 10;
    localparam int HT = 3;

    logic fast_clock  = 1'b0;
    logic reset       = 1'b1;
    logic walk_button = 1'b0;
    logic side_sensor = 1'b0;
    logic walk_ack    = 1'b0;
    logic sec_tick;
    logic walk_req;
    logic side_req;
    logic walk_level;
    logic side_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rel   = 0;
    int mcnt  = 0;

    typedef struct {
        bit val;
        int cyc;
    } exp_t;

    exp_t q_wl[$];
    exp_t q_wr[$];
    exp_t q_sl[$];
    exp_t q_sr[$];

    traffic_input_conditioner #(
        .DEBOUNCE_CYCLES  (DB),
        .TICK_DIV         (TD),
        .SENSOR_HOLD_TICKS(HT)
    ) dut (
        .fast_clock (fast_clock),
        .reset      (reset),
        .walk_button(walk_button),
        .side_sensor(side_sensor),
        .walk_ack   (walk_ack),
        .sec_tick   (sec_tick),
        .walk_req   (walk_req),
        .side_req   (side_req),
        .walk_level (walk_level),
        .side_level (side_level)
    );

    always #5 fast_clock = ~fast_clock;

    always @(posedge fast_clock) cyc <= cyc + 1;

    // Reference tick phase: counts edges since reset release.
    always @(posedge fast_clock or negedge reset) begin
        if (!reset) mcnt <= 0;
        else        mcnt <= (mcnt + 1) % TD;
    end

    function automatic string nm(input int sig);
        case (sig)
            0:       return "walk_level";
            1:       return "walk_req";
            2:       return "side_level";
            default: return "side_req";
        endcase
    endfunction

    task automatic expect_evt(input int sig, input bit val, input int c);
        exp_t e;
        e.val = val;
        e.cyc = c;
        case (sig)
            0:       q_wl.push_back(e);
            1:       q_wr.push_back(e);
            2:       q_sl.push_back(e);
            default: q_sr.push_back(e);
        endcase
    endtask

    task automatic check_change(input int sig, input bit val);
        exp_t e;
        bit   have;
        have  = 1'b0;
        e.val = 1'b0;
        e.cyc = 0;
        case (sig)
            0:       if (q_wl.size() > 0) begin e = q_wl.pop_front(); have = 1'b1; end
            1:       if (q_wr.size() > 0) begin e = q_wr.pop_front(); have = 1'b1; end
            2:       if (q_sl.size() > 0) begin e = q_sl.pop_front(); have = 1'b1; end
            default: if (q_sr.size() > 0) begin e = q_sr.pop_front(); have = 1'b1; end
        endcase
        total++;
        if (!have) begin
            bad++;
            $display("FAIL %s: unexpected change to %0b at cycle %0d", nm(sig), val, cyc);
        end else if (e.val != val || e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: got %0b at cycle %0d, expected %0b at cycle %0d",
                     nm(sig), val, cyc, e.val, e.cyc);
        end
    endtask

    task automatic drain(input int sig);
        exp_t e;
        forever begin
            case (sig)
                0:       if (q_wl.size() > 0) e = q_wl.pop_front(); else return;
                1:       if (q_wr.size() > 0) e = q_wr.pop_front(); else return;
                2:       if (q_sl.size() > 0) e = q_sl.pop_front(); else return;
                default: if (q_sr.size() > 0) e = q_sr.pop_front(); else return;
            endcase
            total++;
            bad++;
            $display("FAIL %s: no change seen, expected %0b at cycle %0d", nm(sig), e.val, e.cyc);
        end
    endtask

    // Monitor: samples on the falling edge, checks tick phase and every output change.
    initial begin
        logic [3:0] prev;
        logic [3:0] cur;
        prev = '0;
        forever begin
            @(negedge fast_clock);
            cur = {side_req, side_level, walk_req, walk_level};
            total++;
            if (!reset) begin
                if ({cur, sec_tick} != 5'b0) begin
                    bad++;
                    $display("FAIL reset_state: outputs %b sec_tick %b at cycle %0d, expected all 0",
                             cur, sec_tick, cyc);
                end
            end else if (sec_tick !== (mcnt == TD - 1)) begin
                bad++;
                $display("FAIL sec_tick: got %b at cycle %0d, expected %b",
                         sec_tick, cyc, (mcnt == TD - 1));
            end
            for (int i = 0; i < 4; i++) begin
                if (cur[i] != prev[i]) check_change(i, cur[i]);
            end
            prev = cur;
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge fast_clock);
            #1;
        end
    endtask

    function automatic int next_tick(input int c);
        int t;
        t = c;
        for (int i = 0; i < TD; i++) begin
            if (((t - rel) % TD) == TD - 1) return t;
            t++;
        end
        return t;
    endfunction

    initial begin
        int c;
        int p;
        int lv;
        int t1;

        // Reset with raw inputs toggling.
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            adv(1);
            walk_button = i[0];
            side_sensor = ~i[0];
        end
        walk_button = 1'b0;
        side_sensor = 1'b0;
        adv(2);
        rel   = cyc;
        reset = 1'b1;

        // Clean press, acknowledge, hold, release.
        adv(3);
        c = cyc;
        walk_button = 1'b1;
        expect_evt(0, 1'b1, c + 6);
        expect_evt(1, 1'b1, c + 7);
        adv(10);
        c = cyc;
        walk_ack = 1'b1;
        expect_evt(1, 1'b0, c + 1);
        adv(1);
        walk_ack = 1'b0;
        adv(10);
        c = cyc;
        walk_button = 1'b0;
        expect_evt(0, 1'b0, c + 6);
        adv(10);

        // Acknowledge without a request.
        walk_ack = 1'b1;
        adv(1);
        walk_ack = 1'b0;
        adv(3);

        // Three-cycle glitch is filtered.
        walk_button = 1'b1;
        adv(3);
        walk_button = 1'b0;
        adv(10);

        // Bounce 1-0-1 restarts the debounce window.
        c = cyc;
        walk_button = 1'b1;
        adv(2);
        walk_button = 1'b0;
        adv(1);
        walk_button = 1'b1;
        expect_evt(0, 1'b1, c + 9);
        expect_evt(1, 1'b1, c + 10);
        adv(14);

        // Release, clear, then new press edge collides with walk_ack.
        c = cyc;
        walk_button = 1'b0;
        expect_evt(0, 1'b0, c + 6);
        adv(1);
        c = cyc;
        walk_ack = 1'b1;
        expect_evt(1, 1'b0, c + 1);
        adv(1);
        walk_ack = 1'b0;
        adv(10);
        p = cyc;
        walk_button = 1'b1;
        expect_evt(0, 1'b1, p + 6);
        expect_evt(1, 1'b1, p + 7);
        adv(6);
        walk_ack = 1'b1;
        adv(1);
        walk_ack = 1'b0;
        adv(3);
        c = cyc;
        walk_ack = 1'b1;
        expect_evt(1, 1'b0, c + 1);
        adv(1);
        walk_ack = 1'b0;
        c = cyc;
        walk_button = 1'b0;
        expect_evt(0, 1'b0, c + 6);
        adv(10);

        // Side sensor held through three counted ticks, then dropped.
        c = cyc;
        side_sensor = 1'b1;
        lv = c + 6;
        expect_evt(2, 1'b1, lv);
        t1 = next_tick(lv + 1);
        expect_evt(3, 1'b1, t1 + 21);
        adv(t1 + 25 - cyc);
        c = cyc;
        side_sensor = 1'b0;
        expect_evt(2, 1'b0, c + 6);
        expect_evt(3, 1'b0, c + 7);
        adv(10);

        // Sensor high for only two counted ticks.
        c = cyc;
        side_sensor = 1'b1;
        lv = c + 6;
        expect_evt(2, 1'b1, lv);
        t1 = next_tick(lv + 1);
        adv(t1 + 9 - cyc);
        side_sensor = 1'b0;
        expect_evt(2, 1'b0, t1 + 15);
        adv(30);

        // Reset mid-operation with walk_req set and hold count at 2.
        c = cyc;
        walk_button = 1'b1;
        side_sensor = 1'b1;
        expect_evt(0, 1'b1, c + 6);
        expect_evt(1, 1'b1, c + 7);
        lv = c + 6;
        expect_evt(2, 1'b1, lv);
        t1 = next_tick(lv + 1);
        adv(t1 + 13 - cyc);
        c = cyc;
        reset = 1'b0;
        expect_evt(0, 1'b0, c);
        expect_evt(1, 1'b0, c);
        expect_evt(2, 1'b0, c);
        adv(3);
        walk_button = 1'b0;
        side_sensor = 1'b0;
        adv(2);
        rel   = cyc;
        reset = 1'b1;
        adv(20);

        // Fresh press and a full new hold are required after reset.
        c = cyc;
        walk_button = 1'b1;
        side_sensor = 1'b1;
        expect_evt(0, 1'b1, c + 6);
        expect_evt(1, 1'b1, c + 7);
        lv = c + 6;
        expect_evt(2, 1'b1, lv);
        t1 = next_tick(lv + 1);
        expect_evt(3, 1'b1, t1 + 21);
        adv(t1 + 25 - cyc);
        adv(5);

        for (int s = 0; s < 4; s++) drain(s);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
